// File: rtl/kogge_stone_adder.sv
// Kogge-Stone parallel-prefix adder with a registered result copy.
// Optional signed-overflow outputs ovf/ovf_q when KSA_OVF_EN is defined.
module kogge_stone_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
`ifdef KSA_OVF_EN
    output logic             ovf,
    output logic             ovf_q,
`endif
    output logic [WIDTH-1:0] s_q,
    output logic             c_out_q
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_f;
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // carry-in folded into bit 0 so the tree needs no extra column
    assign g_f = {g[WIDTH-1:1], g[0] | (p[0] & c_in)};

    genvar k, i;
    generate
        for (k = 0; k < LEVELS; k++) begin : lvl
            localparam int D = 1 << k;
            logic [WIDTH-1:0] gi;
            logic [WIDTH-1:0] pi;
            logic [WIDTH-1:0] go;
            logic [WIDTH-1:0] po;
            if (k == 0) begin : src0
                assign gi = g_f;
                assign pi = p;
            end else begin : srcn
                assign gi = lvl[k-1].go;
                assign pi = lvl[k-1].po;
            end
            for (i = 0; i < WIDTH; i++) begin : node
                if (i >= D) begin : comb_n
                    assign go[i] = gi[i] | (pi[i] & gi[i-D]);
                    assign po[i] = pi[i] & pi[i-D];
                end else begin : pass_n
                    assign go[i] = gi[i];
                    assign po[i] = pi[i];
                end
            end
        end
    endgenerate

    assign g_fin = lvl[LEVELS-1].go;
    assign c     = {g_fin[WIDTH-2:0], c_in};
    assign s     = p ^ c;
    assign c_out = g_fin[WIDTH-1];

`ifdef KSA_OVF_EN
    assign ovf = c[WIDTH-1] ^ c_out;

    // registered overflow flag, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf;
    end
`endif

    // registered copy of the sum for clocked consumers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s;
            c_out_q <= c_out;
        end
    end

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Self-checking bench for kogge_stone_adder against a behavioural model.
// Checks ovf/ovf_q too when KSA_OVF_EN is defined.
module tb_kogge_stone_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] s;
    logic         c_out;
    logic [W-1:0] s_q;
    logic         c_out_q;
`ifdef KSA_OVF_EN
    logic         ovf;
    logic         ovf_q;
`endif

    int tests;
    int fails;

    kogge_stone_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .s       (s),
        .c_out   (c_out),
`ifdef KSA_OVF_EN
        .ovf     (ovf),
        .ovf_q   (ovf_q),
`endif
        .s_q     (s_q),
        .c_out_q (c_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model_sum(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic ci);
        int unsigned t;
        t = int'(x) + int'(y) + int'(ci);
        return t[W:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic ci);
        int t;
        t = int'($signed(x)) + int'($signed(y)) + int'(ci);
        return (t > 32767) || (t < -32768);
    endfunction

    task automatic comb_chk(input string tag, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic ci);
        logic [W:0] e;
        a = x; b = y; c_in = ci;
        #2;
        e = model_sum(x, y, ci);
        chk(tag, {15'd0, c_out, s}, {15'd0, e});
`ifdef KSA_OVF_EN
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, model_ovf(x, y, ci)});
`endif
    endtask

    initial begin
        logic [W:0] e;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        #3;
        chk("reset_s_q", {16'd0, s_q}, 32'd0);
        chk("reset_c_out_q", {31'd0, c_out_q}, 32'd0);
`ifdef KSA_OVF_EN
        chk("reset_ovf_q", {31'd0, ovf_q}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        comb_chk("zero", 16'h0000, 16'h0000, 1'b0);
        comb_chk("ones_p0_c1", 16'hFFFF, 16'h0000, 1'b1);
        comb_chk("ones_p_ones_c1", 16'hFFFF, 16'hFFFF, 1'b1);
        comb_chk("min_p_min", 16'h8000, 16'h8000, 1'b0);
        comb_chk("max_p1", 16'h7FFF, 16'h0001, 1'b0);
        comb_chk("zero_c1", 16'h0000, 16'h0000, 1'b1);
        comb_chk("alt_bits", 16'hAAAA, 16'h5555, 1'b1);

        a = 16'hFFFF; b = 16'h0000; c_in = 1'b1;
        #2;
        chk("wrap_s", {16'd0, s}, 32'd0);
        chk("wrap_cout", {31'd0, c_out}, 32'd1);

        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 64; y++)
                for (int ci = 0; ci < 2; ci++)
                    comb_chk("exh_low", W'(x), W'(y), ci[0]);

        for (int n = 0; n < 3000; n++)
            comb_chk("rand_comb", W'($urandom), W'($urandom),
                     1'($urandom));

        @(negedge clk);
        a = 16'h1111; b = 16'h2222; c_in = 1'b0;
        @(posedge clk);
        #1;
        chk("reg_pre_load", {16'd0, s_q}, 32'h3333);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; c_in = 1'b1;
        #1;
        chk("reg_old_hold", {16'd0, s_q}, 32'h3333);
        chk("comb_5556", {16'd0, s}, 32'h5556);
        @(posedge clk);
        #1;
        chk("reg_s_q", {16'd0, s_q}, 32'h5556);
        chk("reg_c_out_q", {31'd0, c_out_q}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_q", {16'd0, s_q}, 32'd0);
        chk("mid_rst_c_out_q", {31'd0, c_out_q}, 32'd0);
        chk("mid_rst_s", {16'd0, s}, 32'h5556);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rel_hold", {16'd0, s_q}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rel_load", {16'd0, s_q}, 32'h5556);

        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
            e = model_sum(a, b, c_in);
            @(posedge clk);
            #1;
            chk("rand_reg", {15'd0, c_out_q, s_q}, {15'd0, e});
`ifdef KSA_OVF_EN
            chk("rand_reg_ovf", {31'd0, ovf_q},
                {31'd0, model_ovf(a, b, c_in)});
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
